// File: rtl/mem_bus_bridge.sv
// ============================================================================
// mem_bus_bridge : core data-memory port to req/ack bus, with stall and timeout
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_bus_bridge #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 255,
  parameter int STALL_IDX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall_i,
  input  logic              flush_i,
  input  logic              cpu_ce_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [3:0]        cpu_sel_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              stallreq_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [DATA_W-1:0] bus_data_o,
  input  logic [DATA_W-1:0] bus_data_i,
  input  logic              bus_ack_i,
  output logic              bus_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_BUSY = 2'd1;
  localparam logic [1:0] c_S_DONE = 2'd2;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rbuf;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_sel;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;
  logic              w_start;
  logic              w_ack;
  logic              w_timeout;
  logic              w_unused;

  assign w_unused  = ^stall_i;

  // rst gating keeps stallreq_o low while reset is held in IDLE
  assign w_start   = rst && (r_state == c_S_IDLE) && cpu_ce_i && !flush_i;
  assign w_ack     = (r_state == c_S_BUSY) && !flush_i && bus_ack_i;
  assign w_timeout = (r_state == c_S_BUSY) && !flush_i && !bus_ack_i
                     && (r_cnt == c_CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_S_IDLE: if (w_start) w_next = c_S_BUSY;
      c_S_BUSY: begin
        if (flush_i)                 w_next = c_S_IDLE;
        else if (w_ack || w_timeout) w_next = c_S_DONE;
      end
      c_S_DONE: if (flush_i || !stall_i[STALL_IDX]) w_next = c_S_IDLE;
      default:  w_next = c_S_IDLE;
    endcase
  end

  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    case (r_state)
      c_S_IDLE: stallreq_o = w_start;
      c_S_BUSY: stallreq_o = 1'b1;
      c_S_DONE: cpu_data_o = r_rbuf;
      default:  stallreq_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_rbuf  <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_sel   <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_start) begin
        r_req   <= 1'b1;
        r_we    <= cpu_we_i;
        r_addr  <= cpu_addr_i;
        r_sel   <= cpu_sel_i;
        r_wdata <= cpu_data_i;
        r_cnt   <= '0;
      end
      if (r_state == c_S_BUSY) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (flush_i) begin
          r_req <= 1'b0;
        end else if (w_ack) begin
          r_req <= 1'b0;
          if (!r_we) r_rbuf <= bus_data_i;
        end else if (w_timeout) begin
          r_req  <= 1'b0;
          r_rbuf <= '0;
          r_err  <= 1'b1;
        end
      end
    end
  end

  assign bus_req_o  = r_req;
  assign bus_we_o   = r_we;
  assign bus_addr_o = r_addr;
  assign bus_sel_o  = r_sel;
  assign bus_data_o = r_wdata;
  assign bus_err_o  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_bridge.sv
// ============================================================================
// tb_mem_bus_bridge : table-driven cycle vectors plus a hand-written write case
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_bridge;

  localparam logic [31:0] c_ADDR  = 32'h0000_0100;
  localparam logic [3:0]  c_SEL   = 4'hF;
  localparam logic [31:0] c_WDATA = 32'hA5A5_A5A5;
  localparam int          c_NV    = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i, cpu_ce_i, cpu_we_i;
  logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
  logic [3:0]  cpu_sel_i, bus_sel_o;
  logic        stallreq_o, bus_req_o, bus_we_o, bus_ack_i, bus_err_o;
  logic [31:0] bus_addr_o, bus_data_o, bus_data_i;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .STALL_IDX(4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_data_o(bus_data_o),
    .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
  );

  typedef struct packed {
    logic        rst;
    logic        stl;
    logic        fl;
    logic        ce;
    logic        we;
    logic [31:0] bd;
    logic        ack;
    logic        e_st;
    logic        e_req;
    logic        e_err;
    logic [31:0] e_cd;
  } vec_t;

  vec_t tbl [c_NV];

  function automatic vec_t mk(input logic r, input logic s, input logic f,
                              input logic c, input logic w, input logic [31:0] bd,
                              input logic a, input logic est, input logic ereq,
                              input logic eerr, input logic [31:0] ecd);
    vec_t v;
    v.rst = r; v.stl = s; v.fl = f; v.ce = c; v.we = w; v.bd = bd; v.ack = a;
    v.e_st = est; v.e_req = ereq; v.e_err = eerr; v.e_cd = ecd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    //            rst stl fl ce we bus_data     ack  st req err cpu_data
    tbl[0]  = mk(0, 0, 0, 1, 0, 32'h0,        0,   0, 0, 0, 32'h0);
    tbl[1]  = mk(1, 0, 0, 1, 0, 32'h0,        0,   1, 0, 0, 32'h0);
    tbl[2]  = mk(1, 0, 0, 1, 0, 32'h0,        0,   1, 1, 0, 32'h0);
    tbl[3]  = mk(1, 0, 0, 1, 0, 32'hDEADBEEF, 1,   1, 1, 0, 32'h0);
    tbl[4]  = mk(1, 1, 1, 1, 0, 32'h0,        0,   0, 0, 0, 32'hDEADBEEF);
    tbl[5]  = mk(1, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0);
    tbl[6]  = mk(1, 0, 0, 1, 0, 32'h0,        0,   1, 0, 0, 32'h0);
    tbl[7]  = mk(1, 0, 0, 0, 0, 32'h0,        0,   1, 1, 0, 32'h0);
    tbl[8]  = mk(1, 0, 0, 0, 0, 32'h0,        0,   1, 1, 0, 32'h0);
    tbl[9]  = mk(1, 0, 0, 0, 0, 32'h0,        0,   1, 1, 0, 32'h0);
    tbl[10] = mk(1, 0, 0, 0, 0, 32'h0,        0,   1, 1, 0, 32'h0);
    tbl[11] = mk(1, 0, 0, 0, 0, 32'h0,        0,   0, 0, 1, 32'h0);
    tbl[12] = mk(1, 0, 0, 0, 0, 32'hFFFFFFFF, 1,   0, 0, 0, 32'h0);
    tbl[13] = mk(1, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0);
    tbl[14] = mk(1, 0, 0, 1, 0, 32'h0,        0,   1, 0, 0, 32'h0);
    tbl[15] = mk(1, 0, 0, 1, 0, 32'h0,        0,   1, 1, 0, 32'h0);
    tbl[16] = mk(1, 0, 1, 1, 0, 32'hCAFEF00D, 1,   1, 1, 0, 32'h0);
    tbl[17] = mk(1, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0);
    tbl[18] = mk(1, 0, 1, 1, 0, 32'h0,        0,   0, 0, 0, 32'h0);
    tbl[19] = mk(1, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0);
    tbl[20] = mk(1, 1, 0, 1, 0, 32'h0,        0,   1, 0, 0, 32'h0);
    tbl[21] = mk(1, 1, 0, 1, 0, 32'h0BADC0DE, 1,   1, 1, 0, 32'h0);
    tbl[22] = mk(1, 1, 0, 1, 0, 32'h0,        0,   0, 0, 0, 32'h0BADC0DE);
    tbl[23] = mk(1, 1, 0, 1, 0, 32'h0,        0,   0, 0, 0, 32'h0BADC0DE);
    tbl[24] = mk(1, 1, 0, 1, 0, 32'h0,        0,   0, 0, 0, 32'h0BADC0DE);
    tbl[25] = mk(1, 0, 0, 1, 0, 32'h0,        0,   0, 0, 0, 32'h0BADC0DE);
    tbl[26] = mk(1, 0, 0, 1, 0, 32'h0,        0,   1, 0, 0, 32'h0);
    tbl[27] = mk(1, 0, 0, 0, 0, 32'h11112222, 1,   1, 1, 0, 32'h0);
    tbl[28] = mk(1, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h11112222);
    tbl[29] = mk(1, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0);
    tbl[30] = mk(1, 0, 0, 1, 0, 32'h0,        0,   1, 0, 0, 32'h0);
    tbl[31] = mk(1, 0, 0, 1, 0, 32'h0,        0,   1, 1, 0, 32'h0);
    tbl[32] = mk(0, 0, 0, 1, 0, 32'h0,        0,   1, 1, 0, 32'h0);
    tbl[33] = mk(1, 0, 0, 0, 0, 32'h0,        0,   0, 0, 0, 32'h0);

    rst = 1'b0; stall_i = '0; flush_i = 1'b0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
    cpu_addr_i = c_ADDR; cpu_sel_i = c_SEL; cpu_data_i = c_WDATA;
    bus_data_i = '0; bus_ack_i = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < c_NV; i++) begin
      @(posedge clk); #1;
      rst        = tbl[i].rst;
      stall_i    = {1'b1, tbl[i].stl, 4'b1010};
      flush_i    = tbl[i].fl;
      cpu_ce_i   = tbl[i].ce;
      cpu_we_i   = tbl[i].we;
      bus_data_i = tbl[i].bd;
      bus_ack_i  = tbl[i].ack;
      @(negedge clk);
      check($sformatf("v%0d stallreq", i), {31'b0, stallreq_o}, {31'b0, tbl[i].e_st});
      check($sformatf("v%0d bus_req", i),  {31'b0, bus_req_o},  {31'b0, tbl[i].e_req});
      check($sformatf("v%0d bus_err", i),  {31'b0, bus_err_o},  {31'b0, tbl[i].e_err});
      check($sformatf("v%0d cpu_data", i), cpu_data_o, tbl[i].e_cd);
      if (tbl[i].e_req) check($sformatf("v%0d bus_addr", i), bus_addr_o, c_ADDR);
    end

    check("reset bus_addr", bus_addr_o, 32'h0);
    check("reset bus_data", bus_data_o, 32'h0);
    check("reset bus_sel", {28'b0, bus_sel_o}, 32'h0);
    check("reset bus_we", {31'b0, bus_we_o}, 32'h0);

    // write: core inputs scrambled during BUSY must not disturb the bus side
    @(posedge clk); #1;
    stall_i = '0; cpu_ce_i = 1'b1; cpu_we_i = 1'b1;
    cpu_addr_i = 32'h0000_0040; cpu_sel_i = 4'b0011; cpu_data_i = 32'h1234_5678;
    @(negedge clk);
    check("wr issue stallreq", {31'b0, stallreq_o}, 32'h1);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      cpu_we_i = 1'b0; cpu_addr_i = 32'hFFFF_FFFF; cpu_sel_i = 4'hC; cpu_data_i = '0;
      bus_data_i = 32'h5555_AAAA; bus_ack_i = (k == 1);
      @(negedge clk);
      check($sformatf("wr busy%0d req", k),  {31'b0, bus_req_o}, 32'h1);
      check($sformatf("wr busy%0d we", k),   {31'b0, bus_we_o}, 32'h1);
      check($sformatf("wr busy%0d addr", k), bus_addr_o, 32'h0000_0040);
      check($sformatf("wr busy%0d sel", k),  {28'b0, bus_sel_o}, 32'h3);
      check($sformatf("wr busy%0d data", k), bus_data_o, 32'h1234_5678);
      check($sformatf("wr busy%0d stallreq", k), {31'b0, stallreq_o}, 32'h1);
    end
    @(posedge clk); #1;
    cpu_ce_i = 1'b0; bus_ack_i = 1'b0; bus_data_i = '0;
    @(negedge clk);
    check("wr done stallreq", {31'b0, stallreq_o}, 32'h0);
    check("wr done req", {31'b0, bus_req_o}, 32'h0);
    check("wr done cpu_data", cpu_data_o, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("wr idle cpu_data", cpu_data_o, 32'h0);
    check("wr idle stallreq", {31'b0, stallreq_o}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
